// File: rtl/mem_access_unit.sv
// mem_access_unit
// MEM-stage load/store unit. Takes the address, store data and memory
// control bits from the EX/MEM register, runs one transaction on the
// data-memory bus and stalls the pipeline until that transaction is done.
// Stores get byte enables and lane-replicated data; loads are aligned and
// sign/zero-extended. Misaligned accesses are flagged and never reach the bus.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   addr_i            byte address from EX/MEM
//   wdata_i           store data from EX/MEM
//   mem_read_i        load request
//   mem_write_i       store request, wins over mem_read_i
//   mask_i            access size: 00 byte, 01 half, 1x word
//   unsigned_ld_i     1 = zero-extend loads, 0 = sign-extend
//   dmem_*_o          bus request side (req, we, be, word address, wdata)
//   dmem_gnt_i        request accepted
//   dmem_rvalid_i     one-cycle response, for reads and writes
//   dmem_rdata_i      read data, valid with dmem_rvalid_i
//   load_data_o       aligned/extended load result, held until next load
//   load_valid_o      load_data_o updated (pulses in the DONE cycle)
//   misalign_o        current access misaligned and dropped
//   stall_o           freeze PC, IF/ID, ID/EX and EX/MEM
module mem_access_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  mem_read_i,
    input  logic                  mem_write_i,
    input  logic [1:0]            mask_i,
    input  logic                  unsigned_ld_i,
    output logic                  dmem_req_o,
    output logic                  dmem_we_o,
    output logic [3:0]            dmem_be_o,
    output logic [ADDR_WIDTH-1:0] dmem_addr_o,
    output logic [DATA_WIDTH-1:0] dmem_wdata_o,
    input  logic                  dmem_gnt_i,
    input  logic                  dmem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] dmem_rdata_i,
    output logic [DATA_WIDTH-1:0] load_data_o,
    output logic                  load_valid_o,
    output logic                  misalign_o,
    output logic                  stall_o
);

    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

    state_t state, state_next;

    logic                  access;
    logic                  is_byte;
    logic                  is_half;
    logic                  is_word;
    logic                  misaligned;
    logic                  start;
    logic [3:0]            be_new;
    logic [DATA_WIDTH-1:0] wdata_new;

    logic                  we_q;
    logic [3:0]            be_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [1:0]            lane_q;
    logic [1:0]            mask_q;
    logic                  unsigned_q;

    logic [7:0]            byte_sel;
    logic [15:0]           half_sel;
    logic [DATA_WIDTH-1:0] load_ext;

    assign access     = mem_read_i | mem_write_i;
    assign is_byte    = (mask_i == 2'b00);
    assign is_half    = (mask_i == 2'b01);
    assign is_word    = mask_i[1];
    assign misaligned = (is_half & addr_i[0]) | (is_word & (addr_i[1:0] != 2'b00));
    assign start      = (state == IDLE) & access & ~misaligned;

    // Byte enables and store data for the incoming access. Narrow stores are
    // replicated across all lanes so the memory only needs the enables.
    always_comb begin
        be_new    = 4'b1111;
        wdata_new = wdata_i;
        if (is_byte) begin
            be_new    = 4'b0001 << addr_i[1:0];
            wdata_new = {4{wdata_i[7:0]}};
        end else if (is_half) begin
            be_new    = 4'b0011 << addr_i[1:0];
            wdata_new = {2{wdata_i[15:0]}};
        end
    end

    // Snapshot of the access taken when leaving IDLE, so the bus request
    // stays stable no matter how long the grant takes.
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q       <= 1'b0;
            be_q       <= 4'b0000;
            wdata_q    <= '0;
            addr_q     <= '0;
            lane_q     <= 2'b00;
            mask_q     <= 2'b00;
            unsigned_q <= 1'b0;
        end else if (start) begin
            we_q       <= mem_write_i;
            be_q       <= be_new;
            wdata_q    <= wdata_new;
            addr_q     <= {addr_i[ADDR_WIDTH-1:2], 2'b00};
            lane_q     <= addr_i[1:0];
            mask_q     <= mask_i;
            unsigned_q <= unsigned_ld_i;
        end
    end

    // Pick the addressed byte/half out of the returned word and extend it.
    always_comb begin
        byte_sel = dmem_rdata_i[{lane_q, 3'b000} +: 8];
        half_sel = dmem_rdata_i[{lane_q[1], 4'b0000} +: 16];
        case (mask_q)
            2'b00:   load_ext = unsigned_q ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            2'b01:   load_ext = unsigned_q ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
            default: load_ext = dmem_rdata_i;
        endcase
    end

    // Load result register; only a completed load may change it, so stores
    // and dropped accesses leave the previous value visible to WB.
    always_ff @(posedge clk) begin
        if (rst) begin
            load_data_o <= '0;
        end else if ((state == RESP) && dmem_rvalid_i && !we_q) begin
            load_data_o <= load_ext;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and outputs. Bus fields are only driven while requesting,
    // so everything outside REQ reads as zero.
    always_comb begin
        state_next   = state;
        dmem_req_o   = 1'b0;
        dmem_we_o    = 1'b0;
        dmem_be_o    = 4'b0000;
        dmem_addr_o  = '0;
        dmem_wdata_o = '0;
        load_valid_o = 1'b0;
        misalign_o   = 1'b0;
        stall_o      = 1'b0;
        case (state)
            IDLE: begin
                if (access) begin
                    if (misaligned) begin
                        misalign_o = 1'b1;
                    end else begin
                        stall_o    = 1'b1;
                        state_next = REQ;
                    end
                end
            end
            REQ: begin
                dmem_req_o   = 1'b1;
                dmem_we_o    = we_q;
                dmem_be_o    = be_q;
                dmem_addr_o  = addr_q;
                dmem_wdata_o = wdata_q;
                stall_o      = 1'b1;
                if (dmem_gnt_i) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                stall_o = 1'b1;
                if (dmem_rvalid_i) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                // Single unstalled cycle: EX/MEM advances at its end, so the
                // same instruction cannot be picked up again in IDLE.
                load_valid_o = ~we_q;
                state_next   = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit
// Self-checking bench for mem_access_unit: a table of hand-computed vectors,
// a reset-in-flight sequence, and randomized accesses checked against a
// byte-level reference model.
module tb_mem_access_unit;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        rd;
        logic        wr;
        logic [1:0]  mask;
        logic        uns;
        int          gntWait;
        int          rvWait;
        logic        expMis;
        logic        expAccess;
        int          expStall;
        logic [3:0]  expBe;
        logic [31:0] expWdata;
        logic [31:0] expLoad;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        mem_read_i;
    logic        mem_write_i;
    logic [1:0]  mask_i;
    logic        unsigned_ld_i;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_addr_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_gnt_i;
    logic        dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;
    logic [31:0] load_data_o;
    logic        load_valid_o;
    logic        misalign_o;
    logic        stall_o;

    int total = 0;
    int bad   = 0;

    logic        obsMis;
    logic        reqEver;
    logic [3:0]  reqBe;
    logic [31:0] reqAddr;
    logic        reqWe;
    logic [31:0] reqWdata;
    logic        stable;
    int          stallCycles;
    int          lvCount;
    logic [31:0] loadAfter;
    logic        timedOut;

    mem_access_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .mem_read_i   (mem_read_i),
        .mem_write_i  (mem_write_i),
        .mask_i       (mask_i),
        .unsigned_ld_i(unsigned_ld_i),
        .dmem_req_o   (dmem_req_o),
        .dmem_we_o    (dmem_we_o),
        .dmem_be_o    (dmem_be_o),
        .dmem_addr_o  (dmem_addr_o),
        .dmem_wdata_o (dmem_wdata_o),
        .dmem_gnt_i   (dmem_gnt_i),
        .dmem_rvalid_i(dmem_rvalid_i),
        .dmem_rdata_i (dmem_rdata_i),
        .load_data_o  (load_data_o),
        .load_valid_o (load_valid_o),
        .misalign_o   (misalign_o),
        .stall_o      (stall_o)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Last-resort guard in case the DUT wedges the stimulus thread.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mkVec(input logic [31:0] addr, input logic [31:0] wdata,
                                   input logic [31:0] rdata, input logic rd, input logic wr,
                                   input logic [1:0] mask, input logic uns, input int gw,
                                   input int rw, input logic mis, input logic acc,
                                   input int stall, input logic [3:0] be,
                                   input logic [31:0] wd, input logic [31:0] ld);
        vec_t v;
        v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.rd = rd; v.wr = wr;
        v.mask = mask; v.uns = uns; v.gntWait = gw; v.rvWait = rw;
        v.expMis = mis; v.expAccess = acc; v.expStall = stall; v.expBe = be;
        v.expWdata = wd; v.expLoad = ld;
        return v;
    endfunction

    // Reference model: works in terms of access size in bytes and byte
    // offsets within the word, using plain shifts and masks.
    function automatic vec_t model(input vec_t v, input logic [31:0] prevLoad);
        vec_t r = v;
        int lane = int'(v.addr[1:0]);
        int size = (v.mask == 2'b00) ? 1 : ((v.mask == 2'b01) ? 2 : 4);
        longint unsigned fieldMask = (64'd1 << (8 * size)) - 64'd1;
        longint unsigned low;
        longint unsigned rep;
        longint unsigned raw;
        int first;
        r.expMis    = (v.rd | v.wr) && ((lane % size) != 0);
        r.expAccess = (v.rd | v.wr) && !r.expMis;
        r.expStall  = r.expAccess ? (3 + v.gntWait + v.rvWait) : 0;
        r.expBe     = 4'(((1 << size) - 1) << lane);
        low = longint'(v.wdata) & fieldMask;
        rep = 0;
        for (int k = 0; k < 4; k += size) rep |= low << (8 * k);
        r.expWdata = 32'(rep);
        r.expLoad  = prevLoad;
        if (r.expAccess && !v.wr) begin
            first = (size == 2) ? (lane / 2) * 2 : lane;
            raw = (longint'(v.rdata) >> (8 * first)) & fieldMask;
            if (!v.uns && raw[8 * size - 1]) raw |= ~fieldMask;
            r.expLoad = 32'(raw);
        end
        return r;
    endfunction

    // Presents one EX/MEM access held stable, acts as a bus slave with the
    // requested grant/response delays, and records what the DUT did. Called
    // at a falling edge; returns at the falling edge of the following IDLE.
    task automatic applyStimulus(input vec_t v);
        int   reqSeen  = 0;
        int   respSeen = 0;
        logic inResp   = 1'b0;
        logic stallSeen = 1'b0;
        addr_i = v.addr; wdata_i = v.wdata; mem_read_i = v.rd; mem_write_i = v.wr;
        mask_i = v.mask; unsigned_ld_i = v.uns; dmem_rdata_i = v.rdata;
        dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
        reqEver = 1'b0; stable = 1'b1; stallCycles = 0; lvCount = 0; timedOut = 1'b1;
        obsMis = 1'b0; reqBe = 4'b0; reqAddr = 32'b0; reqWe = 1'b0; reqWdata = 32'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            #1;
            if (cyc == 0) obsMis = misalign_o;
            if (load_valid_o) lvCount++;
            if (dmem_req_o) begin
                if (!reqEver) begin
                    reqBe = dmem_be_o; reqAddr = dmem_addr_o;
                    reqWe = dmem_we_o; reqWdata = dmem_wdata_o;
                end else if (dmem_be_o !== reqBe || dmem_addr_o !== reqAddr ||
                             dmem_we_o !== reqWe || dmem_wdata_o !== reqWdata) begin
                    stable = 1'b0;
                end
                reqEver = 1'b1;
            end
            if (stall_o) begin
                stallCycles++;
                stallSeen = 1'b1;
            end else if (stallSeen || cyc >= 2) begin
                timedOut = 1'b0;
                break;
            end
            dmem_rvalid_i = inResp && (respSeen == v.rvWait);
            if (inResp) respSeen++;
            if (dmem_rvalid_i) inResp = 1'b0;
            dmem_gnt_i = dmem_req_o && (reqSeen == v.gntWait);
            if (dmem_req_o) reqSeen++;
            if (dmem_gnt_i) inResp = 1'b1;
            @(negedge clk);
        end
        loadAfter = load_data_o;
        dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
        mem_read_i = 1'b0; mem_write_i = 1'b0;
        @(negedge clk);
    endtask

    // Compares the recorded transaction against its expected record.
    task automatic checkTxn(input string tag, input vec_t v);
        checkOutput({tag, ".timeout"}, 32'(timedOut), 32'd0);
        checkOutput({tag, ".misalign"}, 32'(obsMis), 32'(v.expMis));
        checkOutput({tag, ".req_seen"}, 32'(reqEver), 32'(v.expAccess));
        checkOutput({tag, ".stall_cycles"}, 32'(stallCycles), 32'(v.expStall));
        checkOutput({tag, ".load_data"}, loadAfter, v.expLoad);
        if (v.expAccess) begin
            checkOutput({tag, ".be"}, 32'(reqBe), 32'(v.expBe));
            checkOutput({tag, ".addr"}, reqAddr, {v.addr[31:2], 2'b00});
            checkOutput({tag, ".we"}, 32'(reqWe), 32'(v.wr));
            checkOutput({tag, ".req_stable"}, 32'(stable), 32'd1);
            checkOutput({tag, ".load_valid_pulses"}, 32'(lvCount), v.wr ? 32'd0 : 32'd1);
            if (v.wr) checkOutput({tag, ".wdata"}, reqWdata, v.expWdata);
        end else begin
            checkOutput({tag, ".load_valid_pulses"}, 32'(lvCount), 32'd0);
        end
    endtask

    // Main sequence: reset, table vectors, reset mid-transaction, random.
    initial begin
        vec_t vecs[14];
        vec_t rv;
        logic [31:0] modelLoad;
        int sel;
        int size;

        // addr, wdata, rdata, rd, wr, mask, uns, gw, rw | mis, acc, stall, be, wdata, load after
        vecs[0]  = mkVec(32'h1003, 32'h000000A5, 32'h0, 0, 1, 2'b00, 0, 0, 0, 0, 1, 3, 4'b1000, 32'hA5A5A5A5, 32'h00000000);
        vecs[1]  = mkVec(32'h2001, 32'h0, 32'h123480FF, 1, 0, 2'b00, 0, 0, 0, 0, 1, 3, 4'b0010, 32'h0, 32'hFFFFFF80);
        vecs[2]  = mkVec(32'h2001, 32'h0, 32'h123480FF, 1, 0, 2'b00, 1, 0, 0, 0, 1, 3, 4'b0010, 32'h0, 32'h00000080);
        vecs[3]  = mkVec(32'h2002, 32'h0, 32'h80010000, 1, 0, 2'b01, 0, 0, 0, 0, 1, 3, 4'b1100, 32'h0, 32'hFFFF8001);
        vecs[4]  = mkVec(32'h2002, 32'h0, 32'h80010000, 1, 0, 2'b01, 1, 0, 0, 0, 1, 3, 4'b1100, 32'h0, 32'h00008001);
        vecs[5]  = mkVec(32'h2000, 32'h0, 32'hDEADBEEF, 1, 0, 2'b10, 0, 3, 1, 0, 1, 7, 4'b1111, 32'h0, 32'hDEADBEEF);
        vecs[6]  = mkVec(32'h2002, 32'h0, 32'h11111111, 1, 0, 2'b10, 0, 0, 0, 1, 0, 0, 4'b0000, 32'h0, 32'hDEADBEEF);
        vecs[7]  = mkVec(32'h2001, 32'h5555, 32'h0, 0, 1, 2'b01, 0, 0, 0, 1, 0, 0, 4'b0000, 32'h0, 32'hDEADBEEF);
        vecs[8]  = mkVec(32'h3004, 32'h12345678, 32'h0, 0, 1, 2'b11, 0, 1, 0, 0, 1, 4, 4'b1111, 32'h12345678, 32'hDEADBEEF);
        vecs[9]  = mkVec(32'h0012, 32'hBEEFCAFE, 32'h99999999, 1, 1, 2'b01, 0, 0, 0, 0, 1, 3, 4'b1100, 32'hCAFECAFE, 32'hDEADBEEF);
        vecs[10] = mkVec(32'h2003, 32'h0, 32'h7F000000, 1, 0, 2'b00, 0, 0, 2, 0, 1, 5, 4'b1000, 32'h0, 32'h0000007F);
        vecs[11] = mkVec(32'h2000, 32'h0, 32'h1234FFFE, 1, 0, 2'b01, 0, 0, 0, 0, 1, 3, 4'b0011, 32'h0, 32'hFFFFFFFE);
        vecs[12] = mkVec(32'h2003, 32'h0, 32'h0, 0, 0, 2'b01, 0, 0, 0, 0, 0, 0, 4'b0000, 32'h0, 32'hFFFFFFFE);
        vecs[13] = mkVec(32'h4006, 32'h0000ABCD, 32'h0, 0, 1, 2'b01, 0, 2, 0, 0, 1, 5, 4'b1100, 32'hABCDABCD, 32'hFFFFFFFE);

        rst = 1'b1;
        addr_i = 32'h0; wdata_i = 32'h0; mem_read_i = 1'b0; mem_write_i = 1'b0;
        mask_i = 2'b00; unsigned_ld_i = 1'b0;
        dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'h0;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset.req", 32'(dmem_req_o), 32'd0);
        checkOutput("reset.be", 32'(dmem_be_o), 32'd0);
        checkOutput("reset.load_data", load_data_o, 32'd0);
        checkOutput("reset.stall", 32'(stall_o), 32'd0);
        checkOutput("reset.load_valid", 32'(load_valid_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] table vectors");
        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i]);
            checkTxn($sformatf("row%0d", i), vecs[i]);
        end

        // Reset while waiting for the response; the late rvalid must vanish.
        $display("[TB] reset during RESP");
        addr_i = 32'h2000; mask_i = 2'b10; mem_read_i = 1'b1; unsigned_ld_i = 1'b0;
        #1;
        checkOutput("rstseq.idle_stall", 32'(stall_o), 32'd1);
        @(negedge clk); #1;
        checkOutput("rstseq.req", 32'(dmem_req_o), 32'd1);
        dmem_gnt_i = 1'b1;
        @(negedge clk);
        dmem_gnt_i = 1'b0;
        #1;
        checkOutput("rstseq.resp_req", 32'(dmem_req_o), 32'd0);
        checkOutput("rstseq.resp_stall", 32'(stall_o), 32'd1);
        rst = 1'b1; mem_read_i = 1'b0;
        @(negedge clk);
        rst = 1'b0; dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hFFFFFFFF;
        #1;
        checkOutput("rstseq.req_after", 32'(dmem_req_o), 32'd0);
        checkOutput("rstseq.be_after", 32'(dmem_be_o), 32'd0);
        checkOutput("rstseq.addr_after", dmem_addr_o, 32'd0);
        checkOutput("rstseq.stall_after", 32'(stall_o), 32'd0);
        checkOutput("rstseq.load_data_after", load_data_o, 32'd0);
        @(negedge clk);
        dmem_rvalid_i = 1'b0;
        #1;
        checkOutput("rstseq.load_valid", 32'(load_valid_o), 32'd0);
        checkOutput("rstseq.stall_idle", 32'(stall_o), 32'd0);
        checkOutput("rstseq.load_data_hold", load_data_o, 32'd0);
        @(negedge clk);

        $display("[TB] random accesses");
        modelLoad = 32'h0;
        for (int n = 0; n < 60; n++) begin
            rv.addr = $urandom; rv.wdata = $urandom; rv.rdata = $urandom;
            rv.mask = 2'($urandom_range(0, 3));
            rv.uns = 1'($urandom_range(0, 1));
            rv.gntWait = $urandom_range(0, 3);
            rv.rvWait = $urandom_range(0, 3);
            size = (rv.mask == 2'b00) ? 1 : ((rv.mask == 2'b01) ? 2 : 4);
            if ($urandom_range(0, 3) != 0) rv.addr = rv.addr & ~(32'(size) - 32'd1);
            sel = $urandom_range(0, 9);
            rv.rd = (sel >= 1 && sel <= 5) || sel == 9;
            rv.wr = sel >= 6;
            rv = model(rv, modelLoad);
            applyStimulus(rv);
            checkTxn($sformatf("rnd%0d", n), rv);
            modelLoad = rv.expLoad;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
